// File: rtl/quadrature_decoder_pkg.sv
// quadrature_decoder_pkg: shared phase encodings and priming length (package qdec_pkg)
package qdec_pkg;
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_t;
    // cycles after reset release during which prev only tracks cur
    localparam int PRIME_LEN = 3;
endpackage

// File: rtl/quadrature_decoder_if.sv
// quadrature_decoder_if: encoder inputs, controls and decoder outputs
//   master: drives a_in, b_in, en, clr; observes count, dir, step, ovf, unf, err
//   slave : the decoder side
interface quadrature_decoder_if #(parameter int WIDTH = 8);
    logic             a_in;
    logic             b_in;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             ovf;
    logic             unf;
    logic             err;
    modport master (output a_in, b_in, en, clr, input count, dir, step, ovf, unf, err);
    modport slave  (input a_in, b_in, en, clr, output count, dir, step, ovf, unf, err);
endinterface

// File: rtl/quadrature_decoder_sync.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit
//   clk, reset (async active-low), d (async in), q (synchronized out)
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic r_meta;
    logic r_sync;
    always_ff @(posedge clk or negedge reset)
        if (!reset) {r_meta, r_sync} <= 2'b00;
        else        {r_meta, r_sync} <= {d, r_meta};
    assign q = r_sync;
endmodule

// File: rtl/quadrature_decoder.sv
// quadrature_decoder: quadrature A/B position counter with step/ovf/unf pulses and sticky error
//   clk, reset (async active-low), bus (quadrature_decoder_if.slave)
//   optional glitch filter enabled by defining QDEC_FILTER_EN (stability length FILT_LEN)
module quadrature_decoder
    import qdec_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FILT_LEN = 3
) (
    input logic                 clk,
    input logic                 reset,
    quadrature_decoder_if.slave bus
);
    if (WIDTH < 2 || WIDTH > 32 || FILT_LEN < 1 || FILT_LEN > 15)
        $error("quadrature_decoder: WIDTH or FILT_LEN out of range");

`ifdef QDEC_FILTER_EN
    // priming also covers the filter delay so the first accepted pair is not seen as a step
    localparam int PRIME_END = PRIME_LEN + FILT_LEN;
`else
    localparam int PRIME_END = PRIME_LEN;
`endif

    logic             w_sync_a;
    logic             w_sync_b;
    logic [1:0]       w_sync;
    logic [1:0]       w_cur;
    logic             w_up;
    logic             w_dn;
    logic             w_ill;
    logic             w_primed;
    logic [1:0]       r_prev;
    logic [4:0]       r_prime;
    logic [WIDTH-1:0] r_count;
    logic             r_dir;
    logic             r_step;
    logic             r_ovf;
    logic             r_unf;
    logic             r_err;

    sync_2ff u_sync_a (.clk(clk), .reset(reset), .d(bus.a_in), .q(w_sync_a));
    sync_2ff u_sync_b (.clk(clk), .reset(reset), .d(bus.b_in), .q(w_sync_b));
    assign w_sync = {w_sync_a, w_sync_b};

`ifdef QDEC_FILTER_EN
    logic [1:0] r_cand;
    logic [1:0] r_cur;
    logic [3:0] r_cnt;
    logic [4:0] w_run;
    // w_run: consecutive cycles w_sync has held its value, including this one
    assign w_run = (w_sync == r_cand) ? {1'b0, r_cnt} + 5'd1 : 5'd1;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_cand <= 2'b00;
            r_cur  <= 2'b00;
            r_cnt  <= 4'd0;
        end else begin
            r_cand <= w_sync;
            r_cnt  <= (w_run >= 5'(FILT_LEN)) ? 4'(FILT_LEN) : w_run[3:0];
            if (w_run >= 5'(FILT_LEN)) r_cur <= w_sync;
        end
    assign w_cur = r_cur;
`else
    assign w_cur = w_sync;
`endif

    assign w_up = (r_prev == PH_00 && w_cur == PH_01) || (r_prev == PH_01 && w_cur == PH_11) ||
                  (r_prev == PH_11 && w_cur == PH_10) || (r_prev == PH_10 && w_cur == PH_00);
    assign w_dn = (r_prev == PH_00 && w_cur == PH_10) || (r_prev == PH_10 && w_cur == PH_11) ||
                  (r_prev == PH_11 && w_cur == PH_01) || (r_prev == PH_01 && w_cur == PH_00);
    // both bits flipping at once cannot come from a legal Gray step
    assign w_ill    = (r_prev ^ w_cur) == 2'b11;
    assign w_primed = r_prime == 5'(PRIME_END);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_prev  <= 2'b00;
            r_prime <= 5'd0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_step  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_prev <= w_cur;
            r_step <= 1'b0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            if (!w_primed) r_prime <= r_prime + 5'd1;
            else if (bus.clr) begin
                r_count <= '0;
                r_err   <= 1'b0;
                r_dir   <= 1'b0;
            end else if (bus.en) begin
                r_err <= r_err | w_ill;
                if (w_up || w_dn) begin
                    r_count <= w_up ? r_count + 1'b1 : r_count - 1'b1;
                    r_dir   <= w_up;
                    r_step  <= 1'b1;
                    r_ovf   <= w_up && &r_count;
                    r_unf   <= w_dn && r_count == '0;
                end
            end
        end

    assign bus.count = r_count;
    assign bus.dir   = r_dir;
    assign bus.step  = r_step;
    assign bus.ovf   = r_ovf;
    assign bus.unf   = r_unf;
    assign bus.err   = r_err;
endmodule
